mem_port_arbiter: RTL

Two-port to one-port memory request arbiter placed between the pipeline's instruction-cache and data-cache miss interfaces and the single line-wide port of the main memory model. Each pipeline-side port uses the team's EN/WR/A/WRITE_DATA/READ_DATA/R request protocol. The arbiter grants one request at a time with round-robin fairness and forwards it to memory. It returns the line and a one-cycle completion pulse to the winning port, and flags memory that never answers.

---
 rtl/mem_if_pkg.sv | 17 +
 rtl/rr_arb2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-miss memory port arbiter: default widths,
// arbiter FSM encoding and the port identifiers used as grant IDs.
package mem_if_pkg;

   localparam int MEM_ADDR_W = 16;
   localparam int MEM_LINE_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_t;

   localparam logic PORT_IC = 1'b0;
   localparam logic PORT_DC = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin choice: a lone requester always wins; on contention the
// port that did not win last time is picked.
module rr_arb2
   import mem_if_pkg::*;
(
   input  logic req_ic,
   input  logic req_dc,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_id
);

   always_comb begin
      gnt_valid = req_ic | req_dc;
      gnt_id    = PORT_IC;
      if (req_ic && req_dc) begin
         gnt_id = ~last_grant;
      end else if (req_dc) begin
         gnt_id = PORT_DC;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Funnels the I-cache and D-cache miss ports onto one line-wide memory port,
// one transaction at a time, and raises a sticky ERR when memory stays silent.
module mem_port_arbiter
   import mem_if_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int LINE_W  = MEM_LINE_W,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IC_EN,
   input  logic              IC_WR,
   input  logic [ADDR_W-1:0] IC_A,
   input  logic [LINE_W-1:0] IC_WRITE_DATA,
   output logic [LINE_W-1:0] IC_READ_DATA,
   output logic              IC_R,
   input  logic              DC_EN,
   input  logic              DC_WR,
   input  logic [ADDR_W-1:0] DC_A,
   input  logic [LINE_W-1:0] DC_WRITE_DATA,
   output logic [LINE_W-1:0] DC_READ_DATA,
   output logic              DC_R,
   output logic              MEM_EN,
   output logic              MEM_WR,
   output logic [ADDR_W-1:0] MEM_A,
   output logic [LINE_W-1:0] MEM_WRITE_DATA,
   input  logic [LINE_W-1:0] MEM_READ_DATA,
   input  logic              MEM_R,
   output logic              ERR,
   output logic [1:0]        DBG_STATE
);

   // Handshake: a requester raises EN with WR/A/WRITE_DATA and holds them until
   // its one-cycle R; memory sees MEM_EN held until its one-cycle MEM_R.
   localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

   arb_state_t        state_q, state_d;
   logic              last_q, last_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic [LINE_W-1:0] mem_wd_q, mem_wd_d;
   logic [LINE_W-1:0] ic_rd_q, ic_rd_d;
   logic [LINE_W-1:0] dc_rd_q, dc_rd_d;
   logic              ic_r_q, ic_r_d;
   logic              dc_r_q, dc_r_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              gnt_valid;
   logic              gnt_id;

   rr_arb2 u_rr (
      .req_ic     (IC_EN),
      .req_dc     (DC_EN),
      .last_grant (last_q),
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id)
   );

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      mem_en_d = mem_en_q;
      mem_wr_d = mem_wr_q;
      mem_a_d  = mem_a_q;
      mem_wd_d = mem_wd_q;
      ic_rd_d  = ic_rd_q;
      dc_rd_d  = dc_rd_q;
      ic_r_d   = 1'b0;
      dc_r_d   = 1'b0;
      cnt_d    = cnt_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               mem_en_d = 1'b1;
               mem_wr_d = (gnt_id == PORT_DC) ? DC_WR : IC_WR;
               mem_a_d  = (gnt_id == PORT_DC) ? DC_A : IC_A;
               mem_wd_d = (gnt_id == PORT_DC) ? DC_WRITE_DATA : IC_WRITE_DATA;
               last_d   = gnt_id;
               cnt_d    = 8'd0;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (MEM_R) begin
               mem_en_d = 1'b0;
               state_d  = ST_DONE;
               ic_r_d   = (last_q == PORT_IC);
               dc_r_d   = (last_q == PORT_DC);
               if (!mem_wr_q && last_q == PORT_IC) ic_rd_d = MEM_READ_DATA;
               if (!mem_wr_q && last_q == PORT_DC) dc_rd_d = MEM_READ_DATA;
            end else if (cnt_q != TO_MAX) begin
               // Saturating wait counter; ERR latches as it reaches the limit.
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == TO_MAX) err_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         last_q   <= PORT_IC;
         mem_en_q <= 1'b0;
         mem_wr_q <= 1'b0;
         mem_a_q  <= '0;
         mem_wd_q <= '0;
         ic_rd_q  <= '0;
         dc_rd_q  <= '0;
         ic_r_q   <= 1'b0;
         dc_r_q   <= 1'b0;
         cnt_q    <= 8'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         mem_en_q <= mem_en_d;
         mem_wr_q <= mem_wr_d;
         mem_a_q  <= mem_a_d;
         mem_wd_q <= mem_wd_d;
         ic_rd_q  <= ic_rd_d;
         dc_rd_q  <= dc_rd_d;
         ic_r_q   <= ic_r_d;
         dc_r_q   <= dc_r_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   assign IC_READ_DATA   = ic_rd_q;
   assign DC_READ_DATA   = dc_rd_q;
   assign IC_R           = ic_r_q;
   assign DC_R           = dc_r_q;
   assign MEM_EN         = mem_en_q;
   assign MEM_WR         = mem_wr_q;
   assign MEM_A          = mem_a_q;
   assign MEM_WRITE_DATA = mem_wd_q;
   assign ERR            = err_q;
   assign DBG_STATE      = state_q;

endmodule
